mu0_seq: RTL and testbench
==========================

# mu0_seq

Parametrised second-generation MU0 control sequencer. It decodes the 4-bit opcode held in IR and the accumulator flags, then drives the datapath enables, ALU function select and memory request. Compared with the first-generation control FSM, it adds a memory ready handshake with a wait-state watchdog, a resumable halt, illegal-opcode trapping, a retired-instruction counter and optional logic ALU operations. It sits between the IR/ACC flag outputs and the datapath mux/enable inputs of the MU0 core.

## Interface
- CNT_W, 16: width of the retired-instruction counter.
- WAIT_W, 4: width of the wait-state counter; watchdog limit is 2^WAIT_W-1 cycles.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- opcode  in  4  IR[15:12].
- accz  in  1  accumulator equals zero.
- acc_msb  in  1  accumulator sign bit.
- mem_ack  in  1  memory completes the current request this cycle.
- run  in  1  resume pulse from HALT.
- asel  out  1  address mux: 0 = PC, 1 = IR address field.
- bsel  out  1  ALU B mux: 0 = address path, 1 = memory data.
- accce, pcce, irce  out  1 each  register clock enables.
- accoe  out  1  ACC drives the write-data bus.
- alufs  out  3  ALU function: 000 pass B, 001 B+1, 010 A+B, 011 A-B, 100 AND, 101 OR, 110 XOR.
- memrq  out  1  memory request.
- rnw  out  1  1 = read, 0 = write.
- halted  out  1  high in HALT.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky watchdog timeout flag.
- instr_count  out  CNT_W  retired instructions, saturating.

## Operation
- States: RST, FETCH, EXEC, HALT, ERR. Outputs are decoded combinationally from state, opcode, flags and mem_ack.
- RST: all enables 0, memrq 0, rnw 1, alufs 000. The first rising edge after reset is released moves the FSM to FETCH.
- FETCH: asel 0, bsel 0, alufs 001, memrq 1, rnw 1. irce and pcce equal mem_ack. On mem_ack the FSM moves to EXEC; otherwise it stays in FETCH.
- EXEC LDA(0000)/ADD(0010)/SUB(0011): asel 1, bsel 1, memrq 1, rnw 1, accce = mem_ack, alufs 000/010/011. On ack the FSM moves to FETCH.
- EXEC STO(0001): asel 1, accoe 1, memrq 1, rnw 0, all register enables 0. On ack the FSM moves to FETCH.
- EXEC JMP(0100), and JGE(0101) taken when acc_msb=0, and JNE(0110) taken when accz=0: fetch from target. asel 1, bsel 0, alufs 001, memrq 1, rnw 1, irce = pcce = mem_ack. On ack the FSM stays in EXEC.
- Untaken JGE/JNE: same as FETCH from PC; on ack the FSM stays in EXEC.
- STP(0111): no memrq; next state is HALT.
- HALT: all enables 0, memrq 0, halted 1. run=1 moves the FSM to FETCH; run is ignored in any other state.
- Opcodes 1011–1111 are illegal. So are 1000–1010 when the macro is absent. An illegal opcode asserts no outputs, sets illegal, and moves the FSM to ERR.
- ERR: outputs as RST, with illegal or bus_err held. Only reset exits ERR.
- Watchdog: the wait counter increments each cycle with memrq=1 and mem_ack=0. It clears on ack and on any state change. When it reaches all-ones it sets bus_err and the FSM moves to ERR.
- instr_count increments by 1 on each EXEC ack and on STP entering HALT. It holds at all-ones.
- Reset mid-access: the FSM goes to RST immediately. All flags and counters clear, and memrq drops combinationally.

## Timing
- Reset values: asel 0, bsel 0, accce 0, pcce 0, irce 0, accoe 0, alufs 000, memrq 0, rnw 1, halted 0, illegal 0, bus_err 0, instr_count 0.
- Zero-wait memory: LDA/ADD/SUB/STO take 2 cycles (FETCH+EXEC). Jumps take 1 EXEC cycle per chained fetch.
- Each wait state adds one cycle. Outputs stay stable while waiting.
- Flags are registered; they are visible the cycle after the triggering edge.

## Configuration
- MU0_SEQ_LOGIC_EN defined: opcodes 1000/1001/1010 execute as AND/OR/XOR memory-operand ops, decoded like ADD with alufs 100/101/110.
- MU0_SEQ_LOGIC_EN undefined: those opcodes are illegal and go to ERR.

## Test plan
- Release reset, mem_ack always 1, LDA then ADD: one RST cycle, then FETCH/EXEC alternate. accce pulses in EXEC with alufs 000 then 010. instr_count = 2.
- STO with mem_ack delayed 3 cycles: memrq=1, rnw=0, accoe=1 held for 4 cycles, no enables, then FETCH.
- JNE with accz=0, then with accz=1: asel=1 in the first case, asel=0 in the second. Both assert irce=pcce=1 on ack and remain in EXEC.
- STP, then run pulse 5 cycles later: halted=1 for 5 cycles, then FETCH. instr_count increments once for STP.
- mem_ack held 0 with WAIT_W=4: bus_err=1 after 15 wait cycles, FSM in ERR, memrq=0. run has no effect; reset clears.
- Opcode 1000 without the macro: illegal=1 and ERR. With the macro: alufs=100, accce on ack.

Source files
------------

// File: rtl/mu0_seq.sv
// -----------------------------------------------------------------------------
// mu0_seq -- second-generation MU0 control sequencer.
//
// Decodes IR[15:12] and the accumulator flags and drives the datapath
// enables, the ALU function select and the memory request. Adds to the
// first-generation control FSM:
//   * a memory ready handshake (mem_ack) with a wait-state watchdog
//   * a resumable HALT (leave with a run pulse)
//   * illegal-opcode trapping into a sticky ERR state
//   * a saturating retired-instruction counter
//   * optional logic ALU ops (AND/OR/XOR) when MU0_SEQ_LOGIC_EN is defined;
//     without the macro, opcodes 1000/1001/1010 trap as illegal
//
// Parameters
//   CNT_W   width of the retired-instruction counter
//   WAIT_W  width of the wait-state counter (watchdog limit 2^WAIT_W-1), >= 2
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   opcode[3:0]  in   IR[15:12]
//   accz         in   accumulator equals zero
//   acc_msb      in   accumulator sign bit
//   mem_ack      in   memory completes the current request this cycle
//   run          in   resume pulse, only honoured in HALT
//   asel         out  address mux: 0 = PC, 1 = IR address field
//   bsel         out  ALU B mux: 0 = address path, 1 = memory data
//   accce        out  ACC clock enable
//   pcce         out  PC clock enable
//   irce         out  IR clock enable
//   accoe        out  ACC drives the write-data bus
//   alufs[2:0]   out  ALU function select
//   memrq        out  memory request
//   rnw          out  1 = read, 0 = write
//   halted       out  high in HALT
//   illegal      out  sticky illegal-opcode flag
//   bus_err      out  sticky watchdog timeout flag
//   instr_count  out  retired instructions, saturating at all-ones
//   dbg_state    out  current FSM state (0 RST, 1 FETCH, 2 EXEC, 3 HALT, 4 ERR)
//
// Handshake: a memory access is offered by holding memrq (with asel/bsel/
// rnw/accoe/alufs) stable every cycle until the cycle in which mem_ack is
// high; that cycle completes the access, and only in that cycle are the
// register enables (accce/pcce/irce) asserted. mem_ack with memrq low is
// ignored.
// -----------------------------------------------------------------------------
module mu0_seq #(
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             accz,
  input  logic             acc_msb,
  input  logic             mem_ack,
  input  logic             run,
  output logic             asel,
  output logic             bsel,
  output logic             accce,
  output logic             pcce,
  output logic             irce,
  output logic             accoe,
  output logic [2:0]       alufs,
  output logic             memrq,
  output logic             rnw,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STO = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JGE = 4'b0101;
  localparam logic [3:0] OP_JNE = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
`ifdef MU0_SEQ_LOGIC_EN
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
`endif

  localparam logic [2:0] FS_PASSB = 3'b000;
  localparam logic [2:0] FS_INCB  = 3'b001;
  localparam logic [2:0] FS_ADD   = 3'b010;
  localparam logic [2:0] FS_SUB   = 3'b011;
`ifdef MU0_SEQ_LOGIC_EN
  localparam logic [2:0] FS_AND   = 3'b100;
  localparam logic [2:0] FS_OR    = 3'b101;
  localparam logic [2:0] FS_XOR   = 3'b110;
`endif

  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  // Value of the wait counter on the last tolerated wait cycle: the
  // increment out of this value would reach all-ones, which is the timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic retire;       // an instruction completes at this edge
  logic set_illegal;  // EXEC decoded an unsupported opcode
  logic wait_hit;     // this wait cycle exhausts the watchdog
  logic jmp_taken;

  assign jmp_taken = (opcode == OP_JMP)
                   | ((opcode == OP_JGE) & ~acc_msb)
                   | ((opcode == OP_JNE) & ~accz);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    asel        = 1'b0;
    bsel        = 1'b0;
    accce       = 1'b0;
    pcce        = 1'b0;
    irce        = 1'b0;
    accoe       = 1'b0;
    alufs       = FS_PASSB;
    memrq       = 1'b0;
    rnw         = 1'b1;
    halted      = 1'b0;
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;

    unique case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        alufs = FS_INCB;
        memrq = 1'b1;
        irce  = mem_ack;
        pcce  = mem_ack;
        if (mem_ack) state_d = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB
`ifdef MU0_SEQ_LOGIC_EN
          , OP_AND, OP_OR, OP_XOR
`endif
          : begin
            asel  = 1'b1;
            bsel  = 1'b1;
            memrq = 1'b1;
            accce = mem_ack;
            case (opcode)
              OP_ADD:  alufs = FS_ADD;
              OP_SUB:  alufs = FS_SUB;
`ifdef MU0_SEQ_LOGIC_EN
              OP_AND:  alufs = FS_AND;
              OP_OR:   alufs = FS_OR;
              OP_XOR:  alufs = FS_XOR;
`endif
              default: alufs = FS_PASSB;
            endcase
            if (mem_ack) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end

          OP_STO: begin
            asel  = 1'b1;
            accoe = 1'b1;
            memrq = 1'b1;
            rnw   = 1'b0;
            if (mem_ack) begin
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end

          // A jump is itself the fetch of the next instruction: taken jumps
          // fetch from the IR address field, untaken ones from PC. Either way
          // the new opcode lands in IR and the FSM stays in EXEC.
          OP_JMP, OP_JGE, OP_JNE: begin
            asel  = jmp_taken;
            alufs = FS_INCB;
            memrq = 1'b1;
            irce  = mem_ack;
            pcce  = mem_ack;
            if (mem_ack) retire = 1'b1;
          end

          OP_STP: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end

          default: begin
            set_illegal = 1'b1;
            state_d     = S_ERR;
          end
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
        if (run) state_d = S_FETCH;
      end

      S_ERR: begin
        state_d = S_ERR;
      end

      default: begin
        state_d = S_RST;
      end
    endcase

    // Watchdog overrides whatever the decode chose.
    wait_hit = memrq & ~mem_ack & (wait_q == WAIT_LAST);
    if (wait_hit) state_d = S_ERR;
  end

  // ---------------------------------------------------------------------------
  // Counter / flag next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || mem_ack) begin
      wait_d = '0;
    end else if (memrq) begin
      wait_d = wait_q + WAIT_ONE;
    end

    illegal_d = illegal_q | set_illegal;
    bus_err_d = bus_err_q | wait_hit;

    count_d = count_q;
    if (retire && (count_q != CNT_MAX)) count_d = count_q + CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      count_q   <= count_d;
    end
  end

  assign illegal     = illegal_q;
  assign bus_err     = bus_err_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mu0_seq.sv
// -----------------------------------------------------------------------------
// tb_mu0_seq -- directed bench for mu0_seq.
// A per-cycle vector table walks a program from reset (LDA, ADD, STO with
// wait states, JNE/JGE/JMP taken and untaken, SUB, STP, HALT/run, opcode
// 1000). Hand-written sequences cover counter saturation, the watchdog
// boundary and reset in the middle of an access.
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_mu0_seq;

  localparam int CNT_W  = 4;
  localparam int WAIT_W = 4;

  localparam logic [2:0] ST_RST = 3'd0, ST_FETCH = 3'd1, ST_EXEC = 3'd2,
                         ST_HALT = 3'd3, ST_ERR = 3'd4;

  // ctl = {asel,bsel,accce,pcce,irce,accoe,alufs[2:0],memrq,rnw,halted}
  localparam logic [11:0] C_IDLE   = 12'b0_0_0_0_0_0_000_0_1_0;
  localparam logic [11:0] C_HALT   = 12'b0_0_0_0_0_0_000_0_1_1;
  localparam logic [11:0] C_F_ACK  = 12'b0_0_0_1_1_0_001_1_1_0;
  localparam logic [11:0] C_F_WAIT = 12'b0_0_0_0_0_0_001_1_1_0;
  localparam logic [11:0] C_LDA    = 12'b1_1_1_0_0_0_000_1_1_0;
  localparam logic [11:0] C_LDA_W  = 12'b1_1_0_0_0_0_000_1_1_0;
  localparam logic [11:0] C_ADD    = 12'b1_1_1_0_0_0_010_1_1_0;
  localparam logic [11:0] C_SUB    = 12'b1_1_1_0_0_0_011_1_1_0;
  localparam logic [11:0] C_STO    = 12'b1_0_0_0_0_1_000_1_0_0;
  localparam logic [11:0] C_JT_ACK = 12'b1_0_0_1_1_0_001_1_1_0;
`ifdef MU0_SEQ_LOGIC_EN
  localparam logic [11:0] C_AND    = 12'b1_1_1_0_0_0_100_1_1_0;
  localparam logic [11:0] C_OR     = 12'b1_1_1_0_0_0_101_1_1_0;
  localparam logic [11:0] C_XOR    = 12'b1_1_1_0_0_0_110_1_1_0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic accz = 1'b0, acc_msb = 1'b0, mem_ack = 1'b0, run = 1'b0;
  logic asel, bsel, accce, pcce, irce, accoe, memrq, rnw, halted;
  logic illegal, bus_err;
  logic [2:0] alufs;
  logic [CNT_W-1:0] instr_count;
  logic [2:0] dbg_state;
  logic [11:0] ctl;

  always #5 clk = ~clk;

  mu0_seq #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .accz(accz),
    .acc_msb(acc_msb), .mem_ack(mem_ack), .run(run),
    .asel(asel), .bsel(bsel), .accce(accce), .pcce(pcce), .irce(irce),
    .accoe(accoe), .alufs(alufs), .memrq(memrq), .rnw(rnw),
    .halted(halted), .illegal(illegal), .bus_err(bus_err),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  assign ctl = {asel, bsel, accce, pcce, irce, accoe, alufs, memrq, rnw, halted};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]       op;
    logic             z;
    logic             m;
    logic             ack;
    logic             rn;
    logic [11:0]      ctl;
    logic [2:0]       st;
    logic             ill;
    logic             berr;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] op, input logic z, input logic m,
                              input logic ack, input logic rn, input logic [11:0] c,
                              input logic [2:0] s, input logic il, input logic be,
                              input logic [CNT_W-1:0] n);
    vec_t v;
    v.op = op; v.z = z; v.m = m; v.ack = ack; v.rn = rn;
    v.ctl = c; v.st = s; v.ill = il; v.berr = be; v.cnt = n;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic [3:0] op, input logic z, input logic m,
                       input logic ack, input logic rn);
    opcode = op; accz = z; acc_msb = m; mem_ack = ack; run = rn;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // ---- program table: one row per clock, counts are values before the edge
    add(4'b0000, 0, 0, 1, 0, C_IDLE,   ST_RST,   0, 0, 0);
    add(4'b0000, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 0);
    add(4'b0000, 0, 0, 1, 0, C_LDA,    ST_EXEC,  0, 0, 0);
    add(4'b0010, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 1);
    add(4'b0010, 0, 0, 1, 0, C_ADD,    ST_EXEC,  0, 0, 1);
    add(4'b0001, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 2);
    for (int k = 0; k < 3; k++)
      add(4'b0001, 0, 0, 0, 0, C_STO,  ST_EXEC,  0, 0, 2);
    add(4'b0001, 0, 0, 1, 0, C_STO,    ST_EXEC,  0, 0, 2);
    add(4'b0110, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 3);
    add(4'b0110, 0, 0, 1, 0, C_JT_ACK, ST_EXEC,  0, 0, 3);
    add(4'b0110, 1, 0, 1, 0, C_F_ACK,  ST_EXEC,  0, 0, 4);
    add(4'b0101, 0, 1, 0, 0, C_F_WAIT, ST_EXEC,  0, 0, 5);
    add(4'b0101, 0, 0, 1, 0, C_JT_ACK, ST_EXEC,  0, 0, 5);
    add(4'b0100, 1, 1, 1, 0, C_JT_ACK, ST_EXEC,  0, 0, 6);
    add(4'b0011, 0, 0, 1, 0, C_SUB,    ST_EXEC,  0, 0, 7);
    add(4'b0111, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 8);
    add(4'b0111, 0, 0, 0, 0, C_IDLE,   ST_EXEC,  0, 0, 8);
    for (int k = 0; k < 4; k++)
      add(4'b0111, 0, 0, 1, 0, C_HALT, ST_HALT,  0, 0, 9);
    add(4'b0111, 0, 0, 1, 1, C_HALT,   ST_HALT,  0, 0, 9);
    add(4'b1000, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 9);
`ifdef MU0_SEQ_LOGIC_EN
    add(4'b1000, 0, 0, 1, 0, C_AND,    ST_EXEC,  0, 0, 9);
    add(4'b1001, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 10);
    add(4'b1001, 0, 0, 1, 0, C_OR,     ST_EXEC,  0, 0, 10);
    add(4'b1010, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 11);
    add(4'b1010, 0, 0, 1, 0, C_XOR,    ST_EXEC,  0, 0, 11);
    add(4'b1011, 0, 0, 1, 0, C_F_ACK,  ST_FETCH, 0, 0, 12);
    add(4'b1011, 0, 0, 1, 0, C_IDLE,   ST_EXEC,  0, 0, 12);
    add(4'b1011, 0, 0, 1, 1, C_IDLE,   ST_ERR,   1, 0, 12);
`else
    add(4'b1000, 0, 0, 1, 0, C_IDLE,   ST_EXEC,  0, 0, 9);
    add(4'b1000, 0, 0, 1, 1, C_IDLE,   ST_ERR,   1, 0, 9);
    add(4'b0000, 0, 0, 1, 1, C_IDLE,   ST_ERR,   1, 0, 9);
`endif

    // ---- reset values while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl",   ctl,         C_IDLE);
    chk("rst_state", dbg_state,   ST_RST);
    chk("rst_ill",   illegal,     1'b0);
    chk("rst_berr",  bus_err,     1'b0);
    chk("rst_cnt",   instr_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table walk
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].op, tbl[i].z, tbl[i].m, tbl[i].ack, tbl[i].rn);
      #1;
      chk($sformatf("row%0d_ctl", i),   ctl,         tbl[i].ctl);
      chk($sformatf("row%0d_state", i), dbg_state,   tbl[i].st);
      chk($sformatf("row%0d_ill", i),   illegal,     tbl[i].ill);
      chk($sformatf("row%0d_berr", i),  bus_err,     tbl[i].berr);
      chk($sformatf("row%0d_cnt", i),   instr_count, tbl[i].cnt);
      @(negedge clk);
    end

    // ---- saturating counter: chained JMPs retire one per cycle
    reset_dut();
    drive(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (25) @(negedge clk);
    #1;
    chk("sat_cnt",   instr_count, 4'hF);
    chk("sat_state", dbg_state,   ST_EXEC);
    @(negedge clk);
    #1;
    chk("sat_hold",  instr_count, 4'hF);

    // ---- watchdog: 14 waits tolerated in FETCH and in EXEC, 15 trip it
    reset_dut();
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 14; k++) begin
      #1;
      chk($sformatf("wd_f%0d_ctl", k), ctl, C_F_WAIT);
      chk($sformatf("wd_f%0d_st", k),  dbg_state, ST_FETCH);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    #1;
    chk("wd_f14_berr", bus_err, 1'b0);
    chk("wd_f14_ctl",  ctl,     C_F_ACK);
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 14; k++) begin
      #1;
      chk($sformatf("wd_e%0d_ctl", k), ctl, C_LDA_W);
      chk($sformatf("wd_e%0d_st", k),  dbg_state, ST_EXEC);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    #1;
    chk("wd_e14_berr", bus_err, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      chk($sformatf("wd_t%0d_st", k), dbg_state, ST_FETCH);
      chk($sformatf("wd_t%0d_be", k), bus_err,   1'b0);
      @(negedge clk);
    end
    #1;
    chk("wd_err_state", dbg_state, ST_ERR);
    chk("wd_err_berr",  bus_err,   1'b1);
    chk("wd_err_ctl",   ctl,       C_IDLE);
    chk("wd_err_ill",   illegal,   1'b0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("wd_run_state", dbg_state, ST_ERR);
    chk("wd_run_berr",  bus_err,   1'b1);
    reset = 1'b1;
    #1;
    chk("wd_rst_state", dbg_state, ST_RST);
    chk("wd_rst_berr",  bus_err,   1'b0);
    @(negedge clk);
    reset = 1'b0;

    // ---- reset in the middle of an access
    drive(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    chk("mid_memrq_pre", memrq,       1'b1);
    chk("mid_cnt_pre",   instr_count, 2);
    chk("mid_state_pre", dbg_state,   ST_EXEC);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_memrq", memrq,       1'b0);
    chk("mid_ctl",   ctl,         C_IDLE);
    chk("mid_state", dbg_state,   ST_RST);
    chk("mid_cnt",   instr_count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
